alu_packet_responder: RTL and testbench
=======================================

# alu_packet_responder

Device-side packet engine for the UART ALU. Sits between the UART receiver byte stream and the UART transmitter byte stream. It parses host command packets (opcode, reserved byte, 16-bit little-endian total length, payload) and produces the response bytes: an echo of the payload, or a 32-bit sum of the payload words. It is the responder to the host/bench initiator that sends packets such as EC 00 05 00 12.

## Interface
- No parameters; all widths fixed.
- clk_i  in  1  system clock
- rst_i  in  1  reset; one clock, asynchronous, active-high
- rx_data_i  in  8  byte from UART RX
- rx_valid_i  in  1  rx_data_i valid
- rx_ready_o  out  1  engine accepts the byte this cycle (transfer = valid & ready)
- tx_data_o  out  8  response byte to UART TX (registered)
- tx_valid_o  out  1  tx_data_o valid (registered)
- tx_ready_i  in  1  UART TX accepts the byte (transfer = valid & ready)
- err_o  out  1  one-cycle pulse on protocol error
- busy_o  out  1  high in any state other than OPCODE

## Operation
- Packet: byte0 opcode, byte1 reserved (ignored), byte2 LEN[7:0], byte3 LEN[15:8]. LEN = total packet bytes including the 4-byte header; payload = LEN-4 bytes.
- Opcodes: 0xEC echo; 0xAD add; anything else unknown.
- FSM states: OPCODE, RSVD, LEN_LO, LEN_HI, PAYLOAD, DRAIN, RESULT.
- OPCODE -> RSVD -> LEN_LO -> LEN_HI, one state per accepted byte; opcode and LEN are latched.
- On LEN_HI accept:
  - If LEN < 4: err_o pulse; return to OPCODE; no output.
  - Else if opcode unknown: err_o pulse; go to DRAIN if LEN > 4, otherwise OPCODE.
  - Else if LEN == 4: echo returns to OPCODE with no output; add goes to RESULT with sum 0.
  - Else go to PAYLOAD with remaining = LEN-4 (16-bit down-counter).
- PAYLOAD, echo:
  - Each accepted byte is loaded into the tx register.
  - rx_ready_o = !tx_valid_o || tx_ready_i, so at most one byte is in flight.
- PAYLOAD, add:
  - rx_ready_o = 1.
  - Bytes assemble little-endian into a 32-bit word; on the 4th byte the word is added to the accumulator, modulo 2^32.
  - On the last payload byte, a partial word (1–3 bytes) is zero-extended and added. Go to RESULT.
- DRAIN: rx_ready_o = 1; accept and discard remaining bytes; no tx output; then OPCODE.
- RESULT:
  - rx_ready_o = 0.
  - Emit the 4 accumulator bytes LSB first via the tx register.
  - After the 4th tx transfer: clear the accumulator; go to OPCODE.
- Echo packet exit: after the last payload byte is accepted, go to OPCODE. The pending tx byte is still delivered. A new opcode may be accepted while that byte is waiting.
- rx_ready_o in header states: 1, except in OPCODE it is 0 while tx_valid_o is pending from RESULT. That case is impossible by construction, but RTL must gate it.
- tx register: tx_valid_o clears on a transfer unless reloaded in the same cycle. Simultaneous transfer and reload keeps tx_valid_o = 1 with the new data.

## Timing
- Reset values: rx_ready_o 0 during reset, 1 the first cycle after (state OPCODE); tx_valid_o 0, tx_data_o 0x00, err_o 0, busy_o 0; accumulator, counter and opcode cleared.
- Reset mid-packet: abort immediately, drop any pending tx byte, no err_o; the next accepted byte is treated as an opcode.
- Echo latency: byte accepted in cycle N -> tx_valid_o high with that byte in cycle N+1. Sustained throughput is 1 byte/cycle when tx_ready_i is held high.
- Add latency: last payload byte accepted in cycle N -> first result byte valid in cycle N+1. Subsequent bytes follow one per tx transfer.
- err_o is asserted in the cycle after the LEN_HI transfer, for exactly one cycle.
- LEN = 0xFFFF: the counter must not wrap; 65531 payload bytes are processed.
- rx_valid_i low stalls any state without side effects. tx_ready_i low holds tx_data_o and tx_valid_o stable.

## Test plan
- Echo: send EC 00 05 00 12 with tx_ready_i = 1 -> tx emits exactly 0x12, err_o never pulses, busy_o returns to 0.
- Echo backpressure: EC 00 07 00 A1 B2 C3 with tx_ready_i toggling every other cycle -> tx emits A1 B2 C3 in order; no byte is dropped or duplicated; rx_ready_o low while the tx register is full and not draining.
- Add: AD 00 0C 00 FF FF FF FF 02 00 00 00 -> tx emits 01 00 00 00 (the sum wraps modulo 2^32).
- Add edge cases:
  - AD 00 06 00 34 12 -> tx emits 34 12 00 00 (zero-extended partial word).
  - AD 00 04 00 -> tx emits 00 00 00 00.
- Errors:
  - 55 00 06 00 AA BB -> err_o pulses once, no tx output; a following EC 00 05 00 7E -> tx 7E.
  - EC 00 02 00 -> err_o pulses once; the next byte is parsed as an opcode.
- Reset mid-packet: assert rst_i after AD 00 0C 00 01 -> all outputs at reset values. Then EC 00 05 00 42 -> tx 42 only.

Source files
------------

// File: rtl/alu_packet_responder.sv
// Packet engine behind the UART ALU: parses opcode/reserved/LEN headers and
// answers with a payload echo or a 32-bit little-endian sum of payload words.
module alu_packet_responder (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic       rx_ready_o,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic       err_o,
    output logic       busy_o
);
    typedef enum logic [2:0] {
        S_OPCODE, S_RSVD, S_LEN_LO, S_LEN_HI, S_PAYLOAD, S_DRAIN, S_RESULT
    } state_t;

    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'hAD;

    state_t      state_q, state_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [7:0]  len_lo_q, len_lo_d;
    logic [15:0] rem_q, rem_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] word_q, word_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [2:0]  res_idx_q, res_idx_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        tx_res_q, tx_res_d;
    logic        err_q, err_d;

    logic        rx_ready_c;
    logic        rx_fire;
    logic        tx_slot_free;
    logic        is_echo, is_add;
    logic [15:0] len_full;
    logic [31:0] word_next;
    logic [31:0] sum_next;
    logic [31:0] acc_shift;
    logic        enter_result;
    logic [31:0] result_val;

    assign is_echo      = (opcode_q == OP_ECHO);
    assign is_add       = (opcode_q == OP_ADD);
    assign len_full     = {rx_data_i, len_lo_q};
    assign tx_slot_free = !tx_valid_q || tx_ready_i;
    assign word_next    = word_q | ({24'd0, rx_data_i} << {byte_idx_q, 3'b000});
    assign sum_next     = acc_q + word_next;
    assign acc_shift    = acc_q >> {res_idx_q[1:0], 3'b000};
    assign rx_fire      = rx_valid_i && rx_ready_c;

    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        len_lo_d     = len_lo_q;
        rem_d        = rem_q;
        acc_d        = acc_q;
        word_d       = word_q;
        byte_idx_d   = byte_idx_q;
        res_idx_d    = res_idx_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        tx_res_d     = tx_res_q;
        err_d        = 1'b0;
        rx_ready_c   = 1'b0;
        enter_result = 1'b0;
        result_val   = 32'd0;

        if (tx_valid_q && tx_ready_i) begin
            tx_valid_d = 1'b0;
            tx_res_d   = 1'b0;
        end

        case (state_q)
            S_OPCODE: begin
                rx_ready_c = !(tx_valid_q && tx_res_q);
                if (rx_fire) begin
                    opcode_d = rx_data_i;
                    state_d  = S_RSVD;
                end
            end
            S_RSVD: begin
                rx_ready_c = 1'b1;
                if (rx_fire) state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
                rx_ready_c = 1'b1;
                if (rx_fire) begin
                    len_lo_d = rx_data_i;
                    state_d  = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                rx_ready_c = 1'b1;
                if (rx_fire) begin
                    rem_d      = len_full - 16'd4;
                    acc_d      = 32'd0;
                    word_d     = 32'd0;
                    byte_idx_d = 2'd0;
                    if (len_full < 16'd4) begin
                        err_d   = 1'b1;
                        state_d = S_OPCODE;
                    end else if (!is_echo && !is_add) begin
                        err_d   = 1'b1;
                        state_d = (len_full > 16'd4) ? S_DRAIN : S_OPCODE;
                    end else if (len_full == 16'd4) begin
                        if (is_add) begin
                            state_d      = S_RESULT;
                            enter_result = 1'b1;
                        end else begin
                            state_d = S_OPCODE;
                        end
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (is_echo) begin
                    rx_ready_c = tx_slot_free;
                    if (rx_fire) begin
                        tx_data_d  = rx_data_i;
                        tx_valid_d = 1'b1;
                        tx_res_d   = 1'b0;
                        rem_d      = rem_q - 16'd1;
                        if (rem_q == 16'd1) state_d = S_OPCODE;
                    end
                end else begin
                    rx_ready_c = 1'b1;
                    if (rx_fire) begin
                        rem_d = rem_q - 16'd1;
                        // A short final word is already zero-extended in word_next.
                        if (byte_idx_q == 2'd3 || rem_q == 16'd1) begin
                            acc_d      = sum_next;
                            word_d     = 32'd0;
                            byte_idx_d = 2'd0;
                        end else begin
                            word_d     = word_next;
                            byte_idx_d = byte_idx_q + 2'd1;
                        end
                        if (rem_q == 16'd1) begin
                            state_d      = S_RESULT;
                            enter_result = 1'b1;
                            result_val   = sum_next;
                        end
                    end
                end
            end
            S_DRAIN: begin
                rx_ready_c = 1'b1;
                if (rx_fire) begin
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1) state_d = S_OPCODE;
                end
            end
            S_RESULT: begin
                if (res_idx_q == 3'd4) begin
                    if (tx_valid_q && tx_ready_i) begin
                        acc_d   = 32'd0;
                        state_d = S_OPCODE;
                    end
                end else if (tx_slot_free) begin
                    tx_data_d  = acc_shift[7:0];
                    tx_valid_d = 1'b1;
                    tx_res_d   = 1'b1;
                    res_idx_d  = res_idx_q + 3'd1;
                end
            end
            default: state_d = S_OPCODE;
        endcase

        // Load result byte 0 straight away unless an echo byte still occupies the slot.
        if (enter_result) begin
            if (tx_slot_free) begin
                tx_data_d  = result_val[7:0];
                tx_valid_d = 1'b1;
                tx_res_d   = 1'b1;
                res_idx_d  = 3'd1;
            end else begin
                res_idx_d  = 3'd0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_OPCODE;
            opcode_q   <= 8'd0;
            len_lo_q   <= 8'd0;
            rem_q      <= 16'd0;
            acc_q      <= 32'd0;
            word_q     <= 32'd0;
            byte_idx_q <= 2'd0;
            res_idx_q  <= 3'd0;
            tx_data_q  <= 8'd0;
            tx_valid_q <= 1'b0;
            tx_res_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            len_lo_q   <= len_lo_d;
            rem_q      <= rem_d;
            acc_q      <= acc_d;
            word_q     <= word_d;
            byte_idx_q <= byte_idx_d;
            res_idx_q  <= res_idx_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tx_res_q   <= tx_res_d;
            err_q      <= err_d;
        end
    end

    assign rx_ready_o = rx_ready_c && !rst_i;
    assign tx_data_o  = tx_data_q;
    assign tx_valid_o = tx_valid_q;
    assign err_o      = err_q;
    assign busy_o     = (state_q != S_OPCODE);
endmodule

// File: tb/tb_alu_packet_responder.sv
// Bench for alu_packet_responder: packet-level reference model, per-cycle
// compare process, directed packets with literal expectations, random packets.
module tb_alu_packet_responder;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       err;
    logic       busy;

    always #5 clk = ~clk;

    alu_packet_responder dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .rx_ready_o (rx_ready),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .err_o      (err),
        .busy_o     (busy)
    );

    int checks = 0;
    int passed = 0;
    bit abort  = 0;
    int tx_mode = 0;

    // reference model state
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [7:0]  m_add[$];
    logic [7:0]  pkt[$];
    int          m_pos = 0;
    int          m_mode = 0;   // 0 header, 1 echo payload, 2 add payload, 3 discard
    int          m_rem = 0;
    logic [7:0]  m_op = 8'd0;
    logic [15:0] m_len = 16'd0;
    bit          err_pend = 0;
    bit          lat_pend = 0;
    logic [7:0]  lat_byte = 8'd0;
    int          err_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    endtask

    task automatic finish_add(input bit slot_free);
        logic [31:0] s;
        s = 32'd0;
        for (int i = 0; i < m_add.size(); i++)
            s = s + ({24'd0, m_add[i]} << (8 * (i % 4)));
        for (int k = 0; k < 4; k++) exp_q.push_back(8'((s >> (8 * k)) & 32'hFF));
        if (slot_free) begin
            lat_pend = 1;
            lat_byte = s[7:0];
        end
    endtask

    task automatic model_byte(input logic [7:0] b, input bit slot_free);
        if (m_mode == 0) begin
            if (m_pos == 0) m_op = b;
            if (m_pos == 2) m_len[7:0] = b;
            if (m_pos == 3) m_len[15:8] = b;
            if (m_pos < 3) m_pos++;
            else begin
                m_pos = 0;
                if (m_len < 16'd4) err_pend = 1;
                else if (m_op != 8'hEC && m_op != 8'hAD) begin
                    err_pend = 1;
                    if (m_len > 16'd4) begin
                        m_mode = 3;
                        m_rem  = int'(m_len) - 4;
                    end
                end else begin
                    m_rem = int'(m_len) - 4;
                    m_add.delete();
                    if (m_rem == 0) begin
                        if (m_op == 8'hAD) finish_add(slot_free);
                    end else m_mode = (m_op == 8'hEC) ? 1 : 2;
                end
            end
        end else begin
            m_rem--;
            if (m_mode == 1) begin
                exp_q.push_back(b);
                lat_pend = 1;
                lat_byte = b;
            end
            if (m_mode == 2) m_add.push_back(b);
            if (m_rem == 0) begin
                if (m_mode == 2) finish_add(slot_free);
                m_mode = 0;
            end
        end
    endtask

    // compare process: all DUT outputs sampled on the falling edge
    bit         prev_stall = 0;
    logic [7:0] prev_data  = 8'd0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete(); got_q.delete(); m_add.delete();
                m_pos = 0; m_mode = 0; m_rem = 0;
                err_pend = 0; lat_pend = 0; prev_stall = 0;
            end else begin
                chk("err_pulse", {31'd0, err}, {31'd0, err_pend});
                if (err) err_seen++;
                err_pend = 0;
                if (prev_stall) begin
                    chk("hold_valid", {31'd0, tx_valid}, 32'd1);
                    chk("hold_data", {24'd0, tx_data}, {24'd0, prev_data});
                end
                if (lat_pend) begin
                    chk("lat_valid", {31'd0, tx_valid}, 32'd1);
                    chk("lat_data", {24'd0, tx_data}, {24'd0, lat_byte});
                    lat_pend = 0;
                end
                if (m_mode == 1 && tx_valid && !tx_ready)
                    chk("echo_rx_block", {31'd0, rx_ready}, 32'd0);
                if (tx_valid && tx_ready) begin
                    got_q.push_back(tx_data);
                    if (exp_q.size() == 0) chk("tx_unexpected", {24'd0, tx_data}, 32'h100);
                    else chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
                end
                prev_stall = tx_valid && !tx_ready;
                prev_data  = tx_data;
                if (rx_valid && rx_ready) model_byte(rx_data, !tx_valid || tx_ready);
            end
        end
    end

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (tx_mode)
                0: tx_ready = 1'b1;
                1: tx_ready = ~tx_ready;
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // inputs change only 1 time unit after a rising edge
    task automatic send_byte(input logic [7:0] b);
        int  n;
        bit  ok;
        if (abort) return;
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            ok = rx_ready;
            @(posedge clk); #1;
            n++;
        end while (!ok && n < 2000);
        rx_valid = 1'b0;
        if (!ok) begin
            chk("rx_timeout", 32'd1, 32'd0);
            abort = 1;
        end
    endtask

    task automatic send_pkt(input int max_gap);
        for (int i = 0; i < pkt.size(); i++) begin
            send_byte(pkt[i]);
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        if (!abort) begin
            while ((exp_q.size() != 0 || tx_valid || busy) && n < 5000) begin
                @(negedge clk);
                n++;
            end
            if (n >= 5000) begin
                chk("idle_timeout", 32'd1, 32'd0);
                abort = 1;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic check_got(input string name, input int n, input logic [31:0] bytes_le);
        chk({name, "_count"}, got_q.size(), n);
        for (int i = 0; i < n; i++)
            if (i < got_q.size()) chk(name, {24'd0, got_q[i]}, (bytes_le >> (8 * i)) & 32'hFF);
        got_q.delete();
    endtask

    task automatic check_err(input string name, input int n);
        chk(name, err_seen, n);
        err_seen = 0;
    endtask

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'd0; tx_mode = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rx_ready", {31'd0, rx_ready}, 32'd1);
        chk("post_rst_tx_data", {24'd0, tx_data}, 32'd0);
        @(posedge clk); #1;

        pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h12};
        send_pkt(0); wait_idle();
        check_got("echo1", 1, 32'h12); check_err("echo1_err", 0);
        chk("echo1_busy", {31'd0, busy}, 32'd0);

        tx_mode = 1;
        pkt = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'hA1, 8'hB2, 8'hC3};
        send_pkt(0); wait_idle();
        check_got("echo_bp", 3, 32'h00C3B2A1);
        tx_mode = 0;

        pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
        send_pkt(0); wait_idle();
        check_got("add_wrap", 4, 32'h00000001);

        pkt = '{8'hAD, 8'h00, 8'h06, 8'h00, 8'h34, 8'h12};
        send_pkt(0); wait_idle();
        check_got("add_partial", 4, 32'h00001234);

        pkt = '{8'hAD, 8'h00, 8'h04, 8'h00};
        send_pkt(0); wait_idle();
        check_got("add_empty", 4, 32'h00000000); check_err("add_err", 0);

        pkt = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
        send_pkt(0); wait_idle();
        check_got("unk", 0, 32'd0); check_err("unk_err", 1);
        pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h7E};
        send_pkt(0); wait_idle();
        check_got("after_unk", 1, 32'h7E); check_err("after_unk_err", 0);

        pkt = '{8'hEC, 8'h00, 8'h02, 8'h00, 8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A};
        send_pkt(0); wait_idle();
        check_got("short_len", 1, 32'h5A); check_err("short_len_err", 1);

        pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01};
        send_pkt(0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("mid_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("mid_rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("mid_rst_err", {31'd0, err}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        err_seen = 0;
        pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h42};
        send_pkt(0); wait_idle();
        check_got("after_rst", 1, 32'h42); check_err("after_rst_err", 0);

        for (int p = 0; p < 40; p++) begin
            int r, len, nbytes;
            logic [7:0] op;
            r  = $urandom_range(0, 9);
            op = (r < 4) ? 8'hEC : (r < 8) ? 8'hAD : 8'($urandom_range(0, 255));
            if (r >= 8 && (op == 8'hEC || op == 8'hAD)) op = 8'h00;
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : $urandom_range(4, 16);
            nbytes = (len < 4) ? 4 : len;
            pkt.delete();
            pkt.push_back(op);
            pkt.push_back(8'($urandom_range(0, 255)));
            pkt.push_back(8'(len));
            pkt.push_back(8'(len >> 8));
            for (int i = 4; i < nbytes; i++) pkt.push_back(8'($urandom_range(0, 255)));
            tx_mode = $urandom_range(0, 2);
            send_pkt($urandom_range(0, 2));
            if ($urandom_range(0, 2) == 0) wait_idle();
        end
        tx_mode = 0;
        wait_idle();
        chk("final_queue_empty", exp_q.size(), 32'd0);
        chk("final_busy", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
